// File: rtl/prf_pkg.sv
// Shared sizing defaults and index/data types for the physical register file.
package prf_pkg;

  localparam int XLEN     = 64;
  localparam int PREG_NUM = 64;
  localparam int PREG_W   = 6;

  typedef logic [PREG_W-1:0] preg_idx_t;
  typedef logic [XLEN-1:0]   xdata_t;

endpackage

// File: rtl/prf_ready_table.sv
// Ready-bit scoreboard: flush > alloc > write-back update, P0 pinned ready,
// plus per-read-port ready lookup with optional same-cycle write-back forwarding.
module prf_ready_table #(
  parameter int PREG_NUM  = prf_pkg::PREG_NUM,
  parameter int PREG_W    = prf_pkg::PREG_W,
  parameter int NUM_RD    = 4,
  parameter int NUM_WB    = 2,
  parameter int NUM_ALLOC = 2,
  parameter bit BYPASS    = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_WB-1:0]           wb_valid,
  input  logic [NUM_WB*PREG_W-1:0]    wb_addr,
  input  logic [NUM_ALLOC-1:0]        alloc_valid,
  input  logic [NUM_ALLOC*PREG_W-1:0] alloc_addr,
  input  logic [NUM_RD*PREG_W-1:0]    rd_addr,
  output logic [NUM_RD-1:0]           rd_rdy,
  output logic [PREG_NUM-1:0]         rdy_vec
);
  import prf_pkg::*;

  logic [PREG_NUM-1:0] rdy_r;
  logic [PREG_NUM-1:0] alloc_hit_s;
  logic [PREG_NUM-1:0] wb_hit_s;
  logic [PREG_NUM-1:0] rdy_nxt_s;

  // Decode strobes into per-register hit masks; index 0 is never marked.
  always_comb begin
    alloc_hit_s = {PREG_NUM{1'b0}};
    wb_hit_s    = {PREG_NUM{1'b0}};
    for (int j = 0; j < NUM_ALLOC; j++) begin
      alloc_hit_s[alloc_addr[j*PREG_W +: PREG_W]] =
        alloc_hit_s[alloc_addr[j*PREG_W +: PREG_W]] |
        (alloc_valid[j] & (alloc_addr[j*PREG_W +: PREG_W] != {PREG_W{1'b0}}));
    end
    for (int j = 0; j < NUM_WB; j++) begin
      wb_hit_s[wb_addr[j*PREG_W +: PREG_W]] =
        wb_hit_s[wb_addr[j*PREG_W +: PREG_W]] |
        (wb_valid[j] & (wb_addr[j*PREG_W +: PREG_W] != {PREG_W{1'b0}}));
    end
  end

  // Next ready state: alloc beats wb, so a reused index stays not-ready.
  always_comb begin
    rdy_nxt_s = rdy_r;
    if (flush) begin
      rdy_nxt_s = {PREG_NUM{1'b1}};
    end else begin
      rdy_nxt_s = (rdy_r | wb_hit_s) & ~alloc_hit_s;
    end
    rdy_nxt_s[0] = 1'b1;
  end

  // Ready-bit register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_r <= {PREG_NUM{1'b1}};
    end else begin
      rdy_r <= rdy_nxt_s;
    end
  end

  assign rdy_vec = rdy_r;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [PREG_W-1:0] addr_s;
    logic              rdy_s;

    assign addr_s = rd_addr[i*PREG_W +: PREG_W];

    // Per-port lookup; a pending alloc suppresses forwarding of a same-cycle wb.
    always_comb begin
      rdy_s = rdy_r[addr_s];
      if (addr_s == {PREG_W{1'b0}}) begin
        rdy_s = 1'b1;
      end else if (BYPASS && flush) begin
        rdy_s = 1'b1;
      end else if (BYPASS && wb_hit_s[addr_s] && !alloc_hit_s[addr_s]) begin
        rdy_s = 1'b1;
      end else begin
        rdy_s = rdy_r[addr_s];
      end
    end

    assign rd_rdy[i] = rdy_s;
  end

endmodule

// File: rtl/prf_multiport.sv
// Multi-ported physical register file: data array, write priority, bypass
// network and sticky write-back conflict flag around the ready scoreboard.
module prf_multiport #(
  parameter int PREG_NUM  = prf_pkg::PREG_NUM,
  parameter int PREG_W    = prf_pkg::PREG_W,
  parameter int XLEN      = prf_pkg::XLEN,
  parameter int NUM_RD    = 4,
  parameter int NUM_WB    = 2,
  parameter int NUM_ALLOC = 2,
  parameter bit BYPASS    = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_RD*PREG_W-1:0]    rd_addr,
  output logic [NUM_RD*XLEN-1:0]      rd_data,
  output logic [NUM_RD-1:0]           rd_rdy,
  input  logic [NUM_WB-1:0]           wb_valid,
  input  logic [NUM_WB*PREG_W-1:0]    wb_addr,
  input  logic [NUM_WB*XLEN-1:0]      wb_data,
  input  logic [NUM_ALLOC-1:0]        alloc_valid,
  input  logic [NUM_ALLOC*PREG_W-1:0] alloc_addr,
  input  logic                        flush,
  output logic [PREG_NUM-1:0]         rdy_vec,
  output logic                        wb_conflict
);
  import prf_pkg::*;

  logic [XLEN-1:0] mem_r [PREG_NUM];
  logic            wb_conflict_r;
  logic            conflict_s;

  prf_ready_table #(
    .PREG_NUM  (PREG_NUM),
    .PREG_W    (PREG_W),
    .NUM_RD    (NUM_RD),
    .NUM_WB    (NUM_WB),
    .NUM_ALLOC (NUM_ALLOC),
    .BYPASS    (BYPASS)
  ) u_ready (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .rd_addr     (rd_addr),
    .rd_rdy      (rd_rdy),
    .rdy_vec     (rdy_vec)
  );

  // Pairwise detection of two valid ports writing the same nonzero index.
  always_comb begin
    conflict_s = 1'b0;
    for (int j = 0; j < NUM_WB; j++) begin
      for (int m = j + 1; m < NUM_WB; m++) begin
        conflict_s = conflict_s |
          (wb_valid[j] & wb_valid[m] &
           (wb_addr[j*PREG_W +: PREG_W] == wb_addr[m*PREG_W +: PREG_W]) &
           (wb_addr[j*PREG_W +: PREG_W] != {PREG_W{1'b0}}));
      end
    end
  end

  // Data array; iterating upward lets the highest port's write land last.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < PREG_NUM; k++) begin
        mem_r[k] <= {XLEN{1'b0}};
      end
    end else begin
      for (int j = 0; j < NUM_WB; j++) begin
        if (wb_valid[j] && (wb_addr[j*PREG_W +: PREG_W] != {PREG_W{1'b0}})) begin
          mem_r[wb_addr[j*PREG_W +: PREG_W]] <= wb_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Sticky conflict flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_conflict_r <= 1'b0;
    end else begin
      wb_conflict_r <= wb_conflict_r | conflict_s;
    end
  end

  assign wb_conflict = wb_conflict_r;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [PREG_W-1:0] addr_s;
    logic [XLEN-1:0]   data_s;

    assign addr_s = rd_addr[i*PREG_W +: PREG_W];

    // Read mux: P0 reads zero, otherwise newest matching wb beats the array.
    always_comb begin
      data_s = mem_r[addr_s];
      if (addr_s == {PREG_W{1'b0}}) begin
        data_s = {XLEN{1'b0}};
      end else if (BYPASS) begin
        for (int j = 0; j < NUM_WB; j++) begin
          data_s = (wb_valid[j] && (wb_addr[j*PREG_W +: PREG_W] == addr_s)) ?
                   wb_data[j*XLEN +: XLEN] : data_s;
        end
      end else begin
        data_s = mem_r[addr_s];
      end
    end

    assign rd_data[i*XLEN +: XLEN] = data_s;
  end

endmodule
